// File: rtl/record_serializer.sv
// Transmit side of the market-data character link: latches one 3-field record
// and streams it as "<shares>,<nav>,<flow>\n" via per-field double-dabble.
module record_serializer #(
  parameter logic [7:0] DELIM    = 8'h2C,
  parameter logic [7:0] EOL      = 8'h0A,
  parameter bit         FLOW_SGN = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] shares_outstanding,
  input  logic [31:0] nav,
  input  logic [31:0] flow_daily,
  input  logic        rec_valid,
  output logic        rec_ready,
  output logic [7:0]  char_out,
  output logic        char_valid,
  input  logic        char_ready,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CONV = 3'd1,
    S_SIGN = 3'd2,
    S_EMIT = 3'd3,
    S_SEP  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [1:0][31:0]  fld_q, fld_d;          // [0]=nav, [1]=flow_daily
  logic [1:0]        field_q, field_d;
  logic [31:0]       bin_q, bin_d;
  logic [39:0]       bcd_q, bcd_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [3:0]        dig_q, dig_d;
  logic              neg_q, neg_d;
  logic              eol_pend_q, eol_pend_d;
  logic [7:0]        char_out_q, char_out_d;
  logic              char_valid_q, char_valid_d;
  logic              rec_ready_q, rec_ready_d;
  logic              busy_q, busy_d;

  logic              slot_free;
  logic [39:0]       bcd_step;
  logic [31:0]       nxt_raw;
  logic              nxt_is_flow;

  function automatic logic [39:0] dd_step(input logic [39:0] bcd, input logic bit_in);
    logic [39:0] adj;
    adj = bcd;
    for (int i = 0; i < 10; i++) begin
      if (adj[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
      end else begin
        adj[4*i +: 4] = adj[4*i +: 4];
      end
    end
    return {adj[38:0], bit_in};
  endfunction

  // Index of the most significant non-zero digit; 0 when the value is zero.
  function automatic logic [3:0] msd_idx(input logic [39:0] bcd);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (bcd[4*i +: 4] != 4'd0) begin
        idx = i[3:0];
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  function automatic logic is_neg(input logic [31:0] v, input logic is_flow);
    return is_flow & FLOW_SGN & v[31];
  endfunction

  function automatic logic [31:0] field_mag(input logic [31:0] v, input logic is_flow);
    if (is_neg(v, is_flow)) begin
      return (~v) + 32'd1;
    end else begin
      return v;
    end
  endfunction

  assign bcd_step    = dd_step(bcd_q, bin_q[31]);
  assign nxt_raw     = fld_q[field_q[0]];
  assign nxt_is_flow = field_q[0];

  // Next-state, datapath and output-register computation.
  always_comb begin
    state_d      = state_q;
    fld_d        = fld_q;
    field_d      = field_q;
    bin_d        = bin_q;
    bcd_d        = bcd_q;
    cnt_d        = cnt_q;
    dig_d        = dig_q;
    neg_d        = neg_q;
    eol_pend_d   = eol_pend_q;
    char_out_d   = char_out_q;
    slot_free    = !char_valid_q || char_ready;
    if (char_valid_q && char_ready) begin
      char_valid_d = 1'b0;
    end else begin
      char_valid_d = char_valid_q;
    end

    case (state_q)
      S_IDLE: begin
        if (rec_valid && rec_ready_q) begin
          fld_d      = {flow_daily, nav};
          field_d    = 2'd0;
          bin_d      = shares_outstanding;
          bcd_d      = 40'd0;
          cnt_d      = 5'd0;
          neg_d      = 1'b0;
          eol_pend_d = 1'b0;
          state_d    = S_CONV;
        end else begin
          state_d    = S_IDLE;
        end
      end
      S_CONV: begin
        bcd_d = bcd_step;
        bin_d = {bin_q[30:0], 1'b0};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          dig_d   = msd_idx(bcd_step);
          state_d = neg_q ? S_SIGN : S_EMIT;
        end else begin
          state_d = S_CONV;
        end
      end
      S_SIGN: begin
        if (slot_free) begin
          char_out_d   = 8'h2D;
          char_valid_d = 1'b1;
          state_d      = S_EMIT;
        end else begin
          state_d      = S_SIGN;
        end
      end
      S_EMIT: begin
        if (slot_free) begin
          char_out_d   = {4'h3, bcd_q[4*dig_q +: 4]};
          char_valid_d = 1'b1;
          if (dig_q == 4'd0) begin
            state_d = S_SEP;
          end else begin
            dig_d   = dig_q - 4'd1;
          end
        end else begin
          state_d = S_EMIT;
        end
      end
      S_SEP: begin
        // The record only ends once the EOL byte has actually been taken.
        if (field_q == 2'd2) begin
          if (eol_pend_q) begin
            if (char_ready) begin
              eol_pend_d = 1'b0;
              state_d    = S_IDLE;
            end else begin
              state_d    = S_SEP;
            end
          end else if (slot_free) begin
            char_out_d   = EOL;
            char_valid_d = 1'b1;
            eol_pend_d   = 1'b1;
          end else begin
            state_d      = S_SEP;
          end
        end else if (slot_free) begin
          char_out_d   = DELIM;
          char_valid_d = 1'b1;
          field_d      = field_q + 2'd1;
          bin_d        = field_mag(nxt_raw, nxt_is_flow);
          neg_d        = is_neg(nxt_raw, nxt_is_flow);
          bcd_d        = 40'd0;
          cnt_d        = 5'd0;
          state_d      = S_CONV;
        end else begin
          state_d      = S_SEP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    rec_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      fld_q        <= '0;
      field_q      <= 2'd0;
      bin_q        <= 32'd0;
      bcd_q        <= 40'd0;
      cnt_q        <= 5'd0;
      dig_q        <= 4'd0;
      neg_q        <= 1'b0;
      eol_pend_q   <= 1'b0;
      char_out_q   <= 8'h00;
      char_valid_q <= 1'b0;
      rec_ready_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      fld_q        <= fld_d;
      field_q      <= field_d;
      bin_q        <= bin_d;
      bcd_q        <= bcd_d;
      cnt_q        <= cnt_d;
      dig_q        <= dig_d;
      neg_q        <= neg_d;
      eol_pend_q   <= eol_pend_d;
      char_out_q   <= char_out_d;
      char_valid_q <= char_valid_d;
      rec_ready_q  <= rec_ready_d;
      busy_q       <= busy_d;
    end
  end

  assign rec_ready  = rec_ready_q;
  assign char_out   = char_out_q;
  assign char_valid = char_valid_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_record_serializer.sv
// Bench: a signed-flow and an unsigned-flow instance share stimulus; a
// string-formatting model builds each expected byte stream at its accept edge.
`timescale 1ns/1ps
module tb_record_serializer;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [31:0]      shares, nav, flow;
  logic             rec_valid, char_ready;
  logic [1:0]       rr, cv, bz;
  logic [1:0][7:0]  co;

  logic [7:0]       exp_q [2][$];
  int               acc_cnt [2];
  logic             stall_q [2];
  logic [7:0]       stall_byte [2];
  int               n_cmp = 0;
  int               n_err = 0;

  always #5 clk = ~clk;

  record_serializer #(.DELIM(8'h2C), .EOL(8'h0A), .FLOW_SGN(1'b1)) dut0 (
    .clk(clk), .reset_n(reset_n), .shares_outstanding(shares), .nav(nav),
    .flow_daily(flow), .rec_valid(rec_valid), .rec_ready(rr[0]),
    .char_out(co[0]), .char_valid(cv[0]), .char_ready(char_ready), .busy(bz[0])
  );

  record_serializer #(.DELIM(8'h2C), .EOL(8'h0A), .FLOW_SGN(1'b0)) dut1 (
    .clk(clk), .reset_n(reset_n), .shares_outstanding(shares), .nav(nav),
    .flow_daily(flow), .rec_valid(rec_valid), .rec_ready(rr[1]),
    .char_out(co[1]), .char_valid(cv[1]), .char_ready(char_ready), .busy(bz[1])
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic string model_text(input int d, input logic [31:0] s,
                                       input logic [31:0] n, input logic [31:0] f);
    if (d == 0) return $sformatf("%0d,%0d,%0d\n", s, n, $signed(f));
    else        return $sformatf("%0d,%0d,%0d\n", s, n, f);
  endfunction

  // Monitor: sampled mid-cycle, predicts what happens at the next rising edge.
  initial begin
    string      txt;
    logic [7:0] eb;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (reset_n !== 1'b1) begin
          exp_q[d].delete();
          stall_q[d] = 1'b0;
        end else begin
          if (stall_q[d]) begin
            chk($sformatf("stall_valid_dut%0d", d), 64'(cv[d]), 64'd1);
            chk($sformatf("stall_byte_dut%0d", d), 64'(co[d]), 64'(stall_byte[d]));
          end
          if (cv[d] === 1'b1 && char_ready === 1'b1) begin
            eb = (exp_q[d].size() > 0) ? exp_q[d].pop_front() : 8'hFF;
            chk($sformatf("byte_dut%0d", d), 64'(co[d]), 64'(eb));
          end
          stall_q[d]    = (cv[d] === 1'b1) && (char_ready === 1'b0);
          stall_byte[d] = co[d];
          if (rec_valid === 1'b1 && rr[d] === 1'b1) begin
            txt = model_text(d, shares, nav, flow);
            for (int i = 0; i < txt.len(); i++) exp_q[d].push_back(txt[i]);
            acc_cnt[d]++;
          end
        end
      end
    end
  end

  task automatic send(input logic [31:0] s, input logic [31:0] n, input logic [31:0] f);
    for (int i = 0; i < 400; i++) begin
      if (rr === 2'b11) break;
      @(posedge clk); #1;
    end
    chk("send_ready", 64'(rr), 64'(2'b11));
    shares = s; nav = n; flow = f; rec_valid = 1'b1;
    @(posedge clk); #1;
    rec_valid = 1'b0;
    shares = $urandom(); nav = $urandom(); flow = $urandom();
    chk("accept_ready_low", 64'(rr), 64'(2'b00));
    chk("accept_busy_high", 64'(bz), 64'(2'b11));
  endtask

  task automatic wait_idle(input bit rnd, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      char_ready = rnd ? ($urandom_range(0, 9) >= 3) : 1'b1;
      if (rr === 2'b11 && exp_q[0].size() == 0 && exp_q[1].size() == 0) break;
    end
    char_ready = 1'b1;
    chk("idle_ready", 64'(rr), 64'(2'b11));
    chk("idle_busy", 64'(bz), 64'(2'b00));
    chk("idle_drained", 64'(exp_q[0].size() + exp_q[1].size()), 64'd0);
  endtask

  initial begin
    int base0, base1;
    reset_n = 1'b0; rec_valid = 1'b0; char_ready = 1'b1;
    shares = 32'd0; nav = 32'd0; flow = 32'd0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_char_valid", 64'(cv), 64'd0);
    chk("rst_char_out", 64'(co), 64'd0);
    chk("rst_busy", 64'(bz), 64'd0);
    chk("rst_rec_ready", 64'(rr), 64'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("rec_ready_after_rst", 64'(rr), 64'(2'b11));

    // 7,0,12 with first-byte latency check
    send(32'd7, 32'd0, 32'd12);
    for (int k = 1; k <= 33; k++) begin
      @(posedge clk); #1;
      if (k == 32) chk("latency_quiet", 64'(cv), 64'd0);
      else if (k == 33) chk("latency_first", 64'(cv), 64'(2'b11));
    end
    wait_idle(1'b0, 300);

    send(32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF);
    wait_idle(1'b0, 400);
    send(32'd0, 32'd9, 32'h8000_0000);
    wait_idle(1'b0, 400);

    // backpressure on a short record, then random records
    send(32'd123, 32'd45, 32'd6);
    wait_idle(1'b1, 1000);
    repeat (4) begin
      send($urandom() >> $urandom_range(0, 31), $urandom() >> $urandom_range(0, 31),
           $urandom() >> $urandom_range(0, 28));
      wait_idle(1'b1, 2000);
    end

    // reset while nav digits are being emitted
    send(32'd123456, 32'd987654, 32'd5);
    repeat (73) @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    chk("midrec_rst_valid", 64'(cv), 64'd0);
    chk("midrec_rst_busy", 64'(bz), 64'd0);
    reset_n = 1'b1;
    send(32'd1, 32'd2, 32'd3);
    wait_idle(1'b0, 300);

    // rec_valid held with inputs changing every cycle
    base0 = acc_cnt[0];
    base1 = acc_cnt[1];
    rec_valid = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      shares = $urandom();
      nav    = $urandom() >> $urandom_range(0, 31);
      flow   = $urandom() & 32'h7FFF_FFFF;
      @(posedge clk); #1;
      if (acc_cnt[0] - base0 >= 3) break;
    end
    rec_valid = 1'b0;
    chk("held_accepts_dut0", 64'(acc_cnt[0] - base0), 64'd3);
    chk("held_accepts_dut1", 64'(acc_cnt[1] - base1), 64'd3);
    wait_idle(1'b0, 800);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
